mdu_ctrl: RTL and testbench

//  Multiply/divide sequencer owning the single write port of the HI/LO register pair.
//  It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX.
//  It runs multi-cycle multiply and iterative divide, stalls the pipeline while busy, and

---
 rtl/mdu_ctrl_pkg.sv | 21 ++
 rtl/mdu_ctrl_div_iter.sv | 41 ++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: op encodings, sequencer states and divide step count shared by the MDU
package mdu_ctrl_pkg;
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MT   = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;
    localparam int DIV_STEPS = 32;
endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// div_iter: unsigned radix-2 restoring divider, one step per cycle after load
// q/r present the result of the step being taken this cycle, so the last step's outcome is usable before it commits
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] rem, quo, div;
    logic [CW-1:0] left;
    logic [W:0] sh, diff;
    assign sh   = {rem, quo[W-1]};
    assign diff = sh - {1'b0, div};
    assign r    = diff[W] ? sh[W-1:0] : diff[W-1:0];
    assign q    = {quo[W-2:0], ~diff[W]};
    assign busy = left != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            div  <= '0;
            left <= '0;
        end else if (load) begin
            rem  <= '0;
            quo  <= a;
            div  <= b;
            left <= CW'(W);
        end else if (busy) begin
            rem  <= r;
            quo  <= q;
            left <= left - 1'b1;
        end
    end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer driving the single HI/LO write port
// Results land in hilo_hi/hilo_lo on entry to DONE; cancel gates the write pulse combinationally
module mdu_ctrl #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              cancel,
    input  logic [DATA_W-1:0] hi_cur,
    input  logic [DATA_W-1:0] lo_cur,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hilo_hi,
    output logic [DATA_W-1:0] hilo_lo,
    output logic              busy,
    output logic              stall
);
    import mdu_ctrl_pkg::*;
    localparam int MD = MUL_CYCLES > 1 ? MUL_CYCLES - 1 : 1;
    mdu_op_e opc;
    mdu_state_e state;
    logic [5:0] cnt;
    logic q_neg, r_neg, b_zero, go, is_mt, is_div, mul_sgn, div_sgn, d_busy;
    logic [DATA_W-1:0] a_keep, abs_a, abs_b, dq, dr;
    logic [2*DATA_W-1:0] prod, mul_res;
    logic [2*DATA_W-1:0] pipe [MD];
    assign opc     = mdu_op_e'(op);
    assign go      = state == S_IDLE && start && !cancel && op != MDU_NOP && op != MDU_RSVD;
    assign is_mt   = opc == MDU_MTHI || opc == MDU_MTLO;
    assign is_div  = opc == MDU_DIV || opc == MDU_DIVU;
    assign mul_sgn = opc == MDU_MULT;
    assign div_sgn = opc == MDU_DIV;
    // sign-extend to full product width so one unsigned multiply serves MULT and MULTU
    assign prod    = {{DATA_W{mul_sgn & opa[DATA_W-1]}}, opa} * {{DATA_W{mul_sgn & opb[DATA_W-1]}}, opb};
    assign mul_res = MUL_CYCLES == 1 ? prod : pipe[MD-1];
    assign abs_a   = div_sgn && opa[DATA_W-1] ? -opa : opa;
    assign abs_b   = div_sgn && opb[DATA_W-1] ? -opb : opb;
    assign busy    = state != S_IDLE;
    assign hilo_we = state == S_DONE && !cancel;
    assign stall   = (state == S_IDLE && start && !cancel && op >= 3'd1 && op <= 3'd4) || (busy && !hilo_we);
    div_iter #(.W(DATA_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (go && is_div),
        .a    (abs_a),
        .b    (abs_b),
        .busy (d_busy),
        .q    (dq),
        .r    (dr)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MD; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= prod;
            for (int i = 1; i < MD; i++) pipe[i] <= pipe[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hilo_hi <= '0;
            hilo_lo <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            b_zero  <= 1'b0;
            a_keep  <= '0;
        end else if (state != S_IDLE && cancel) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    cnt    <= 6'd1;
                    q_neg  <= div_sgn & (opa[DATA_W-1] ^ opb[DATA_W-1]);
                    r_neg  <= div_sgn & opa[DATA_W-1];
                    b_zero <= opb == '0;
                    a_keep <= opa;
                    if (is_mt) begin
                        hilo_hi <= opc == MDU_MTHI ? opa : hi_cur;
                        hilo_lo <= opc == MDU_MTLO ? opa : lo_cur;
                        state   <= S_DONE;
                    end else if (is_div) begin
                        state <= S_DIV;
                    end else if (MUL_CYCLES == 1) begin
                        {hilo_hi, hilo_lo} <= prod;
                        state <= S_DONE;
                    end else begin
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(MUL_CYCLES - 1)) begin
                        {hilo_hi, hilo_lo} <= mul_res;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    cnt <= cnt + 6'd1;
                    if (d_busy && cnt == 6'(DIV_STEPS)) begin
                        hilo_lo <= b_zero ? '1 : (q_neg ? -dq : dq);
                        hilo_hi <= b_zero ? a_keep : (r_neg ? -dr : dr);
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl, checked every cycle against an arithmetic model
module tb_mdu_ctrl;
    localparam int MULC = 2;
    logic clk = 0, rst = 1, start = 0, cancel = 0;
    logic [2:0] op = 0;
    logic [31:0] opa = 0, opb = 0, hi_cur = 32'h5555, lo_cur = 32'hAB;
    logic hilo_we, busy, stall;
    logic [31:0] hilo_hi, hilo_lo;
    int checks = 0, fails = 0, cyc = 0, m_wcyc = 0, wr_cnt;
    bit chk_en = 0, m_act = 0, e_we, e_stall;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic st0, st_any, busy_t0;

    mdu_ctrl #(.DATA_W(32), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .cancel(cancel), .hi_cur(hi_cur), .lo_cur(lo_cur), .hilo_we(hilo_we),
        .hilo_hi(hilo_hi), .hilo_lo(hilo_lo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int latency(input logic [2:0] o);
        return (o == 3'd5 || o == 3'd6) ? 1 : (o == 3'd1 || o == 3'd2) ? MULC : 33;
    endfunction

    function automatic void model(input logic [2:0] o, input logic [31:0] a, b, hc, lc,
                                  output logic [31:0] h, output logic [31:0] l);
        longint p;
        longint unsigned u;
        h = 0;
        l = 0;
        case (o)
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {h, l} = p; end
            3'd2: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
            3'd3: if (b == 0) begin l = '1; h = a; end
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = 0; end
                  else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
            3'd4: if (b == 0) begin l = '1; h = a; end
                  else begin l = a / b; h = a % b; end
            3'd5: begin h = a; l = lc; end
            3'd6: begin h = hc; l = a; end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) m_act = 0;
        else if (m_act) begin
            if (cancel || cyc == m_wcyc) m_act = 0;
        end else if (start && op != 0 && op != 7 && !cancel) begin
            m_act = 1;
            m_wcyc = cyc + latency(op);
            model(op, opa, opb, hi_cur, lo_cur, m_hi, m_lo);
        end
        cyc++;
    end

    always @(negedge clk) if (chk_en) begin
        e_we = m_act && cyc == m_wcyc && !cancel;
        e_stall = (!m_act && start && op >= 1 && op <= 4 && !cancel) || (m_act && !e_we);
        chk("m_we", hilo_we, e_we);
        chk("m_busy", busy, m_act);
        chk("m_stall", stall, e_stall);
        if (e_we) begin
            chk("m_hi", hilo_hi, m_hi);
            chk("m_lo", hilo_lo, m_lo);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eh, input logic [31:0] el, input string nm);
        int k;
        bit got;
        start = 1; op = o; opa = a; opb = b;
        @(negedge clk);
        st0 = stall; st_any = stall; busy_t0 = busy;
        @(posedge clk); #1;
        start = 0; op = 0;
        got = 0; k = 1;
        while (!got && k <= 40) begin
            @(negedge clk);
            st_any |= stall;
            if (hilo_we) begin
                got = 1;
                chk({nm, "_lat"}, k, lat);
                chk({nm, "_hi"}, hilo_hi, eh);
                chk({nm, "_lo"}, hilo_lo, el);
            end else k++;
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_we", hilo_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hilo_hi, 0);
        chk("rst_lo", hilo_lo, 0);
        @(posedge clk); #1;
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'h00000001, "multu");
        run_op(3'd1, -32'sd3, 32'd5, 2, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult");
        chk("mult_stall_t0", st0, 1);
        run_op(3'd3, -32'sd7, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
        run_op(3'd3, 32'd7, -32'sd2, 33, 32'h00000001, 32'hFFFFFFFD, "div_7_m2");
        run_op(3'd4, 32'd7, 32'd0, 33, 32'h7, 32'hFFFFFFFF, "divu_by0");
        run_op(3'd3, -32'sd7, 32'd0, 33, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, "div_ovf");
        run_op(3'd4, 32'hFFFFFFFF, 32'd16, 33, 32'hF, 32'h0FFFFFFF, "divu_big");
        run_op(3'd5, 32'h1234, 32'h0, 1, 32'h1234, 32'hAB, "mthi");
        chk("mthi_stall", st_any, 0);
        run_op(3'd6, 32'hCAFE, 32'h0, 1, 32'h5555, 32'hCAFE, "mtlo");
        // cancel a divide mid-flight, then a multiply is accepted the very next cycle
        start = 1; op = 3'd4; opa = 1000; opb = 3;
        @(posedge clk); #1;
        start = 0; op = 0;
        repeat (9) @(posedge clk);
        #1 cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        run_op(3'd1, 32'd6, -32'sd7, 2, 32'hFFFFFFFF, 32'hFFFFFFD6, "mult_after_cancel");
        chk("cancel_busy_t11", busy_t0, 0);
        // cancel coinciding with start is not accepted
        start = 1; op = 3'd1; cancel = 1; opa = 9; opb = 9;
        @(posedge clk); #1;
        start = 0; op = 0; cancel = 0;
        @(negedge clk);
        chk("start_cancel_busy", busy, 0);
        repeat (4) @(posedge clk);
        #1;
        // cancel in the write cycle suppresses the write
        start = 1; op = 3'd6; opa = 32'hBEEF;
        @(posedge clk); #1;
        start = 0; op = 0; cancel = 1;
        @(negedge clk);
        chk("done_cancel_we", hilo_we, 0);
        @(posedge clk); #1;
        cancel = 0;
        @(negedge clk);
        chk("done_cancel_busy", busy, 0);
        @(posedge clk); #1;
        // start while busy is ignored: exactly one write
        start = 1; op = 3'd4; opa = 100; opb = 7;
        @(posedge clk); #1;
        start = 0; op = 0;
        repeat (2) @(posedge clk);
        #1 start = 1; op = 3'd2; opa = 3; opb = 3;
        @(posedge clk); #1;
        start = 0; op = 0;
        wr_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_we) begin
                wr_cnt++;
                chk("busy_start_hi", hilo_hi, 2);
                chk("busy_start_lo", hilo_lo, 14);
            end
        end
        chk("busy_start_writes", wr_cnt, 1);
        @(posedge clk); #1;
        // reset in the middle of a divide
        start = 1; op = 3'd3; opa = 100; opb = 7;
        @(posedge clk); #1;
        start = 0; op = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_we", hilo_we, 0);
        chk("midrst_hi", hilo_hi, 0);
        chk("midrst_lo", hilo_lo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_stall", stall, 0);
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
